// File: rtl/calc_sequencer_pkg.sv
// Shared definitions for the calculator sequencer: opcodes, instruction layout, NOP and FSM states.
package calc_pkg;

    localparam int INSTR_W  = 11;
    localparam int CTRL_LSB = 8;
    localparam int RD_LSB   = 6;
    localparam int WE_LSB   = 4;
    localparam int IMM_LSB  = 0;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    // r0 = r0 + 0: leaves every calculator register untouched
    localparam logic [INSTR_W-1:0] INSTR_NOP = {OP_ADD, 2'b00, 2'b00, 4'b0000};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/calc_sequencer_if.sv
// Instruction port between the sequencer (master) and one calculator (slave).
interface calc_sequencer_if;
    logic [1:0]        rd_addr;
    logic [1:0]        we_addr;
    logic [2:0]        control;
    logic signed [3:0] immediate;
    logic signed [3:0] rd_data;

    modport master (output rd_addr, output we_addr, output control, output immediate, input rd_data);
    modport slave  (input rd_addr, input we_addr, input control, input immediate, output rd_data);
endinterface

// File: rtl/calc_prog_mem.sv
// Program store: DEPTH x INSTR_W words, synchronous write, asynchronous read.
module calc_prog_mem
    import calc_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/calc_sequencer.sv
// Replays a loaded program into a calculator, one instruction per clock.
// Optional CALC_SEQ_LOOP_EN adds loop_cnt: the program is repeated loop_cnt+1 times back to back.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [INSTR_W-1:0]  prog_data,
    input  logic [ADDR_W:0]     prog_len,
    input  logic                start,
`ifdef CALC_SEQ_LOOP_EN
    input  logic [3:0]          loop_cnt,
`endif
    output logic                busy,
    output logic                done,
    output logic signed [3:0]   last_result,
    calc_sequencer_if.master    calc
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    seq_state_e         state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W:0]    len_q;
    logic signed [3:0]  last_result_q;

    logic [ADDR_W:0]    len_clamped;
    logic               last_slot;
    logic               pass_again;
    logic               mem_we;
    logic [INSTR_W-1:0] cur_instr;
    logic [INSTR_W-1:0] issued_instr;

    // Writes are only accepted while idle so a running program never changes under the pc
    assign mem_we = prog_we && (state_q == ST_IDLE);

    calc_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (cur_instr)
    );

    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_slot   = ({1'b0, pc_q} == (len_q - (ADDR_W+1)'(1)));

`ifdef CALC_SEQ_LOOP_EN
    logic [3:0] loop_q;
    assign pass_again = (loop_q != 4'd0);
`else
    assign pass_again = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            last_result_q <= '0;
`ifdef CALC_SEQ_LOOP_EN
            loop_q        <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pc_q    <= '0;
                        len_q   <= len_clamped;
`ifdef CALC_SEQ_LOOP_EN
                        loop_q  <= loop_cnt;
`endif
                        state_q <= (len_clamped == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (last_slot) begin
                        pc_q <= '0;
                        if (pass_again) begin
`ifdef CALC_SEQ_LOOP_EN
                            loop_q <= loop_q - 4'd1;
`endif
                        end else begin
                            // rd_data is what the calculator reads for the final instruction
                            last_result_q <= calc.rd_data;
                            state_q       <= ST_DONE;
                        end
                    end else begin
                        pc_q <= pc_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The calculator commits every edge, so anything but RUN must present the NOP
    assign issued_instr = (state_q == ST_RUN) ? cur_instr : INSTR_NOP;

    assign calc.control   = issued_instr[CTRL_LSB +: 3];
    assign calc.rd_addr   = issued_instr[RD_LSB +: 2];
    assign calc.we_addr   = issued_instr[WE_LSB +: 2];
    assign calc.immediate = issued_instr[IMM_LSB +: 4];

    assign busy        = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign last_result = last_result_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural calculator and a program-level reference model.
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    localparam logic [10:0] I_R0_ADD2  = 11'b010_00_00_0010; // r0 = r0 + 2
    localparam logic [10:0] I_R1_SUBM2 = 11'b110_00_01_1110; // r1 = r0 - (-2)
    localparam logic [10:0] I_R2_AND1  = 11'b000_01_10_0001; // r2 = r1 & 1
    localparam logic [10:0] I_R2_ADD0  = 11'b010_10_10_0000; // r2 = r2 + 0
    localparam logic [10:0] I_R3_ADD7  = 11'b010_00_11_0111; // r3 = r0 + 7
    localparam logic [10:0] I_R0_ADD1  = 11'b010_00_00_0001; // r0 = r0 + 1

    typedef struct {
        int len;
        int busy_exp;
    } len_vec_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [10:0]       prog_data = '0;
    logic [ADDR_W:0]   prog_len = '0;
    logic              start = 1'b0;
`ifdef CALC_SEQ_LOOP_EN
    logic [3:0]        loop_cnt = '0;
`endif
    logic              busy;
    logic              done;
    logic signed [3:0] last_result;

    calc_sequencer_if cif();

    calc_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_len    (prog_len),
        .start       (start),
`ifdef CALC_SEQ_LOOP_EN
        .loop_cnt    (loop_cnt),
`endif
        .busy        (busy),
        .done        (done),
        .last_result (last_result),
        .calc        (cif)
    );

    always #5 clk = ~clk;

    // Behavioural calculator: commits one instruction on every rising edge
    logic signed [3:0] regs [4];
    logic signed [3:0] calc_ld_val [4];
    logic              calc_ld = 1'b1;

    function automatic logic signed [3:0] alu(input logic [2:0] op, input logic signed [3:0] a,
                                              input logic signed [3:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_SUB:  return a - b;
            default: return a + b;
        endcase
    endfunction

    assign cif.rd_data = regs[cif.rd_addr];

    always @(posedge clk) begin
        if (calc_ld) begin
            for (int i = 0; i < 4; i++) regs[i] <= calc_ld_val[i];
        end else begin
            regs[cif.we_addr] <= alu(cif.control, regs[cif.rd_addr], cif.immediate);
        end
    end

    int errors = 0;
    int checks = 0;
    int cur_loops = 0;
    int model_last = 0;
    int busy_n, done_n, done_at, nop_bad;
    logic [10:0] seen[$];
    logic [10:0] exp_seq[$];
    logic [10:0] prog_img [DEPTH];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [10:0] presented();
        return {cif.control, cif.rd_addr, cif.we_addr, cif.immediate};
    endfunction

    function automatic int seq_mismatches();
        int n = 0;
        if (seen.size() != exp_seq.size()) return 1000;
        foreach (seen[i]) if (seen[i] !== exp_seq[i]) n++;
        return n;
    endfunction

    task automatic set_regs(input int a, input int b, input int c, input int d);
        @(negedge clk);
        calc_ld = 1'b1;
        calc_ld_val[0] = 4'(a);
        calc_ld_val[1] = 4'(b);
        calc_ld_val[2] = 4'(c);
        calc_ld_val[3] = 4'(d);
        @(negedge clk);
        calc_ld = 1'b0;
    endtask

    task automatic write_slot(input int addr, input logic [10:0] data);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = ADDR_W'(addr);
        prog_data = data;
        prog_img[addr] = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // mode 0 plain, 1 start+write on 2nd busy cycle, 2 reset on 2nd busy cycle, 3 write slot 0 with start
    task automatic run(input int len, input int mode, input logic [10:0] wdata);
        busy_n = 0; done_n = 0; done_at = -1; nop_bad = 0;
        seen.delete();
        @(negedge clk);
        start    = 1'b1;
        prog_len = (ADDR_W+1)'(len);
`ifdef CALC_SEQ_LOOP_EN
        loop_cnt = 4'(cur_loops);
`endif
        if (mode == 3) begin
            prog_we = 1'b1; prog_addr = '0; prog_data = wdata;
        end
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start = 1'b0; prog_we = 1'b0; reset = 1'b0;
            if (busy) begin
                busy_n++;
                seen.push_back(presented());
            end else if (presented() !== INSTR_NOP) begin
                nop_bad++;
            end
            if (done) begin
                done_n++;
                done_at = cyc;
            end
            if (cyc == 2 && mode == 1) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = wdata;
            end
            if (cyc == 2 && mode == 2) reset = 1'b1;
            if ((done_n > 0 && cyc >= done_at + 2) || (mode == 2 && cyc >= 20)) break;
        end
    endtask

    initial begin
        len_vec_t lv [6];
        logic signed [3:0] m [4];
        logic signed [3:0] init [4];
        logic [10:0] ins;
        logic signed [3:0] a;
        int len, eff, mode, idle_bad;
        logic [10:0] wdata;

        for (int i = 0; i < 4; i++) calc_ld_val[i] = 4'sd0;
        lv[0] = '{0, 0};  lv[1] = '{1, 1};   lv[2] = '{4, 4};
        lv[3] = '{16, 16}; lv[4] = '{17, 16}; lv[5] = '{31, 16};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_last", int'(last_result), 0);
        check("rst_nop", int'(presented()), int'(INSTR_NOP));
        reset = 1'b0;
        calc_ld = 1'b0;

        // Four-instruction program
        write_slot(0, I_R0_ADD2);
        write_slot(1, I_R1_SUBM2);
        write_slot(2, I_R2_AND1);
        write_slot(3, I_R2_ADD0);
        set_regs(0, 0, 0, 0);
        run(4, 0, '0);
        exp_seq = '{I_R0_ADD2, I_R1_SUBM2, I_R2_AND1, I_R2_ADD0};
        check("p4_busy", busy_n, 4);
        check("p4_done", done_n, 1);
        check("p4_done_at", done_at, 5);
        check("p4_seq", seq_mismatches(), 0);
        check("p4_r0", int'(regs[0]), 2);
        check("p4_r1", int'(regs[1]), 4);
        check("p4_r2", int'(regs[2]), 0);
        check("p4_last", int'(last_result), 0);

        // Zero-length run
        run(0, 0, '0);
        check("z_busy", busy_n, 0);
        check("z_done_at", done_at, 1);
        check("z_done", done_n, 1);
        check("z_r0", int'(regs[0]), 2);
        check("z_r1", int'(regs[1]), 4);

        // Idle stays NOP
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (presented() !== INSTR_NOP || busy) idle_bad++;
        end
        check("idle_nop", idle_bad, 0);
        check("idle_r0", int'(regs[0]), 2);

        // start and prog_we during a run are both dropped
        set_regs(0, 0, 0, 0);
        run(4, 1, I_R3_ADD7);
        check("cf_busy", busy_n, 4);
        check("cf_done", done_n, 1);
        check("cf_seq", seq_mismatches(), 0);
        check("cf_r3", int'(regs[3]), 0);
        run(1, 0, '0);
        check("cf_readback", (seen.size() > 0) ? int'(seen[0]) : -1, int'(I_R0_ADD2));
        check("cf_rb_last", int'(last_result), 2);

        // Reset on the 2nd RUN cycle
        set_regs(0, 0, 5, 0);
        run(4, 2, '0);
        check("ra_busy", busy_n, 2);
        check("ra_done", done_n, 0);
        check("ra_r0", int'(regs[0]), 2);
        check("ra_r1", int'(regs[1]), 4);
        check("ra_r2", int'(regs[2]), 5);
        check("ra_last", int'(last_result), 0);
        check("ra_nop", int'(presented()), int'(INSTR_NOP));

`ifdef CALC_SEQ_LOOP_EN
        write_slot(0, I_R0_ADD1);
        set_regs(0, 0, 0, 0);
        cur_loops = 2;
        run(1, 0, '0);
        cur_loops = 0;
        check("lp_busy", busy_n, 3);
        check("lp_done", done_n, 1);
        check("lp_done_at", done_at, 4);
        check("lp_r0", int'(regs[0]), 3);
        check("lp_last", int'(last_result), 2);
`endif

        // Randomized programs against the reference model
        model_last = 0;
        for (int it = 0; it < 25; it++) begin
            for (int s = 0; s < DEPTH; s++) begin
                logic [2:0] op;
                int k = $urandom_range(0, 2);
                op = (k == 0) ? OP_AND : (k == 1) ? OP_ADD : OP_SUB;
                write_slot(s, {op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                               4'($urandom_range(0, 15))});
            end
            for (int i = 0; i < 4; i++) init[i] = 4'($urandom_range(0, 15));
            set_regs(int'(init[0]), int'(init[1]), int'(init[2]), int'(init[3]));
            len = $urandom_range(0, 20);
`ifdef CALC_SEQ_LOOP_EN
            cur_loops = $urandom_range(0, 3);
`endif
            mode = ($urandom_range(0, 1) == 1) ? 3 : 0;
            wdata = {OP_ADD, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            if (mode == 3) prog_img[0] = wdata;

            for (int i = 0; i < 4; i++) m[i] = init[i];
            exp_seq.delete();
            eff = (len > DEPTH) ? DEPTH : len;
            if (eff > 0) begin
                for (int p = 0; p <= cur_loops; p++) begin
                    for (int i = 0; i < eff; i++) begin
                        ins = prog_img[i];
                        a = m[ins[7:6]];
                        exp_seq.push_back(ins);
                        if (p == cur_loops && i == eff - 1) model_last = int'(a);
                        m[ins[5:4]] = alu(ins[10:8], a, ins[3:0]);
                    end
                end
            end

            run(len, mode, wdata);
            $display("rand %0d: len=%0d loops=%0d busy=%0d last=%0d", it, len, cur_loops, busy_n,
                     int'(last_result));
            check("rnd_busy", busy_n, exp_seq.size());
            check("rnd_done", done_n, 1);
            check("rnd_done_at", done_at, busy_n + 1);
            check("rnd_seq", seq_mismatches(), 0);
            check("rnd_nop", nop_bad, 0);
            check("rnd_last", int'(last_result), model_last);
            for (int i = 0; i < 4; i++) check("rnd_reg", int'(regs[i]), int'(m[i]));
        end
        cur_loops = 0;

        // Length table, including clamping above DEPTH
        foreach (lv[i]) begin
            run(lv[i].len, 0, '0);
            $display("len %0d: busy=%0d done=%0d", lv[i].len, busy_n, done_n);
            check("tbl_busy", busy_n, lv[i].busy_exp);
            check("tbl_done", done_n, 1);
            check("tbl_done_at", done_at, lv[i].busy_exp + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Initiator for the calculator instruction port. It drives `rd_addr`, `we_addr`, `control` and `immediate`, and samples `rd_data`.
- It replaces hand-driven stimulus with a small loadable program memory, and issues one instruction per `clk`.
- It sits between a host (load, start, done) and one calculator instance. The calculator commits an instruction on every rising `clk` and has no enable.

Parameters:
- DEPTH, 16, number of program slots.
- ADDR_W, 4, program address width; DEPTH must equal 2**ADDR_W.

Ports:
- clk  in  1  sole clock; calculator shares it.
- reset  in  1  synchronous, active-high reset.
- prog_we  in  1  write `prog_data` into slot `prog_addr`; ignored while busy.
- prog_addr  in  ADDR_W  program write address.
- prog_data  in  11  instruction {control[10:8], rd_addr[7:6], we_addr[5:4], immediate[3:0]}.
- prog_len  in  ADDR_W+1  number of instructions to run, 0..DEPTH; sampled on start.
- start  in  1  begin run; honoured only in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last instruction commits.
- last_result  out  4 signed  `rd_data` sampled with the final instruction.
- rd_addr  out  2  to calculator.
- we_addr  out  2  to calculator.
- control  out  3  to calculator.
- immediate  out  4 signed  to calculator.
- rd_data  in  4 signed  from calculator; combinational for the presented instruction.

Behaviour:
- States:
  - IDLE: start with prog_len>0 -> RUN, pc<=0. start with prog_len==0 -> DONE, no instruction issued.
  - RUN: present mem[pc]. The calculator commits it on the next edge. On that edge pc<=pc+1. When pc==len-1, capture rd_data into last_result -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Calculator-side outputs are combinational from state and memory:
  - In RUN they are the fields of mem[pc].
  - Otherwise they are the NOP r0=r0+0 (control=010, rd=00, we=00, imm=0). This guarantees no architectural change while idle.
- Run length:
  - Exactly prog_len consecutive cycles in RUN; no bubbles.
  - Throughput is 1 instruction/clk.
  - done rises the cycle after the last instruction's commit edge.
- Length and counter rules:
  - The length is latched at start, so changes to prog_len mid-run have no effect.
  - prog_len>DEPTH is clamped to DEPTH.
  - pc never wraps.
- Input conflicts:
  - prog_we while busy or in DONE is dropped. The memory is unchanged.
  - start during RUN or DONE is ignored; it is not queued.
  - start and prog_we in the same IDLE cycle: the write completes, and the run sees the new contents.
- Reset:
  - state=IDLE, pc=0, busy=0, done=0, last_result=0, calculator outputs=NOP.
  - Program memory is not cleared.
  - Reset during RUN aborts immediately. Instructions already committed stay in the calculator. No done pulse.
- Arithmetic and width: the sequencer does no arithmetic on data. last_result is a straight 4-bit signed copy.

Optional Feature:
- Macro: CALC_SEQ_LOOP_EN.
- With the macro defined:
  - Extra input loop_cnt[3:0], sampled on start.
  - The program runs loop_cnt+1 times back to back. pc returns to 0 with no bubble cycle.
  - last_result comes from the final pass only.
  - done pulses once, at the end of all passes.
  - Reset mid-loop aborts as above.
- Without the macro: no loop_cnt port; single pass.

Decomposition:
- Package calc_pkg holds:
  - Opcode constants: OP_AND=3'b000, OP_ADD=3'b010, OP_SUB=3'b110.
  - Instruction field offsets and INSTR_W=11.
  - The NOP instruction constant.
  - State encoding for IDLE/RUN/DONE.
- One sub-module, calc_prog_mem: DEPTH x 11 memory with synchronous write and asynchronous read.

Test Plan:
- Load 4 instructions: r0=r0+2, r1=r0-(-2), r2=r1&1, r2=r2+0, with calculator registers 0. Set prog_len=4 and start. -> busy for 4 cycles; r0=2, r1=4, r2=0; last_result=0; done one pulse on cycle 5.
- prog_len=0, start -> done the next cycle; busy never high; calculator registers unchanged.
- Idle for 10 cycles after a run -> calculator outputs stay NOP; registers unchanged (r0=2).
- During a run, pulse start and prog_we to slot 0 with r3=r0+7 -> both ignored. Post-run readback of slot 0 is the original instruction.
- Reset asserted on the 2nd RUN cycle of the 4-instruction program -> r0=2, r1=4, r2 unwritten; done never pulses; state IDLE next cycle.
- CALC_SEQ_LOOP_EN defined: program r0=r0+1, prog_len=1, loop_cnt=2 -> 3 consecutive busy cycles; r0 ends at 3; last_result=2 (the rd_data sampled for the final instruction); single done pulse.
